// File: rtl/mmc_responder_if.sv
// ---------------------------------------------------------------------------
// mmc_responder_if
// Bundles the SPI pins and the backend-facing byte/command signals of the
// MMC/SD SPI-mode card responder.
//
// Handshake semantics (all on the rising edge of the system clock):
//   txLoad/txFull : txLoad is a write strobe. It is accepted when txFull=0,
//                   or when the holding byte is consumed in the same clock.
//                   Otherwise it is ignored. There is no back-pressure beyond
//                   txFull, which the backend must observe itself.
//   rxValid       : one-clock pulse, rxData holds the byte until the next one.
//   cmdValid      : one-clock pulse, cmdIndex/cmdArg/cmdCrc hold the command
//                   until the next well-formed one.
//   cmdError      : one-clock pulse, command dropped, cmd outputs unchanged.
//
// Signals
//   spiCs, spiCk, spiDi : SPI master -> card (chip select active low, mode 0)
//   spiDo               : card -> SPI master (MISO)
//   rxData, rxValid     : received byte stream
//   txData, txLoad      : response byte from the backend
//   txFull              : response holding register occupied
//   cmdValid, cmdError  : command framer result pulses
//   cmdIndex, cmdArg,
//   cmdCrc              : last well-formed command
//   frameState          : command framer state (0 HUNT, 1 ARG, 2 CRC), debug
// Modports
//   slave  : the responder (card side)
//   master : the SPI master plus the backend (bench side)
// ---------------------------------------------------------------------------
interface mmc_responder_if;
    logic        spiCs;
    logic        spiCk;
    logic        spiDi;
    logic        spiDo;
    logic [7:0]  rxData;
    logic        rxValid;
    logic [7:0]  txData;
    logic        txLoad;
    logic        txFull;
    logic        cmdValid;
    logic        cmdError;
    logic [5:0]  cmdIndex;
    logic [31:0] cmdArg;
    logic [6:0]  cmdCrc;
    logic [1:0]  frameState;

    modport slave (
        input  spiCs, spiCk, spiDi, txData, txLoad,
        output spiDo, rxData, rxValid, txFull,
               cmdValid, cmdError, cmdIndex, cmdArg, cmdCrc, frameState
    );

    modport master (
        output spiCs, spiCk, spiDi, txData, txLoad,
        input  spiDo, rxData, rxValid, txFull,
               cmdValid, cmdError, cmdIndex, cmdArg, cmdCrc, frameState
    );
endinterface

// File: rtl/mmc_responder.sv
// ---------------------------------------------------------------------------
// mmc_responder
// SPI mode-0 slave for the MMC/SD bus. The SPI pins are oversampled in the
// system clock domain. Received bytes are deframed into 6-byte MMC commands
// (index, 32-bit argument, CRC7) and response bytes from the backend are
// shifted out MSB first on spiDo.
//
// Parameters
//   SYNC_STAGES : synchroniser depth for spiCs/spiCk/spiDi (>= 2)
//   FILL        : byte shifted out when no response byte is queued
// Ports
//   clock : system clock, rising edge
//   reset : synchronous, active-low reset
//   bus   : mmc_responder_if.slave (SPI pins, rx/tx byte path, command outputs)
// ---------------------------------------------------------------------------
module mmc_responder #(
    parameter int          SYNC_STAGES = 2,
    parameter logic [7:0]  FILL        = 8'hFF
) (
    input  logic           clock,
    input  logic           reset,
    mmc_responder_if.slave bus
);

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        ARG  = 2'd1,
        CRC  = 2'd2
    } frame_t;

    // Pin synchronisers; the last stage is the "pin" seen by the logic.
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] ck_sync;
    logic [SYNC_STAGES-1:0] di_sync;
    logic                   cs_s;
    logic                   ck_s;
    logic                   di_s;
    logic                   cs_q;
    logic                   ck_q;

    // Byte engine
    logic [2:0]  bit_cnt;
    logic [7:0]  rx_shift;
    logic [7:0]  tx_shift;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        spi_do;
    logic [7:0]  hold;
    logic        tx_full;

    // Command framer
    frame_t      frame_state;
    logic [1:0]  arg_n;
    logic [5:0]  idx_tmp;
    logic [31:0] arg_sh;
    logic        cmd_valid;
    logic        cmd_error;
    logic [5:0]  cmd_index;
    logic [31:0] cmd_arg;
    logic [6:0]  cmd_crc;

    // Edge detection on the synchronised pins
    logic        cs_fall;
    logic        ck_rise;
    logic        ck_fall;
    logic        bit_wrap;
    logic        reload;
    logic        consume;
    logic [7:0]  byte_done;

    assign cs_s = cs_sync[SYNC_STAGES-1];
    assign ck_s = ck_sync[SYNC_STAGES-1];
    assign di_s = di_sync[SYNC_STAGES-1];

    assign cs_fall   = cs_q & ~cs_s;
    // SPI clock edges only count while the card is selected.
    assign ck_rise   = ~ck_q & ck_s & ~cs_s;
    assign ck_fall   = ck_q & ~ck_s & ~cs_s;
    assign bit_wrap  = ck_rise && (bit_cnt == 3'd7);
    // The transmit shifter is refilled at selection and at every byte boundary.
    assign reload    = cs_fall | bit_wrap;
    assign consume   = reload & tx_full;
    assign byte_done = {rx_shift[6:0], di_s};

    // -----------------------------------------------------------------------
    // Synchronisers, bit/byte engine and response holding register
    // -----------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset) begin
            cs_sync  <= '1;
            ck_sync  <= '0;
            di_sync  <= '1;
            cs_q     <= 1'b1;
            ck_q     <= 1'b0;
            bit_cnt  <= 3'd0;
            rx_shift <= FILL;
            tx_shift <= FILL;
            rx_data  <= 8'h00;
            rx_valid <= 1'b0;
            spi_do   <= 1'b1;
            hold     <= 8'h00;
            tx_full  <= 1'b0;
        end else begin
            cs_sync  <= {cs_sync[SYNC_STAGES-2:0], bus.spiCs};
            ck_sync  <= {ck_sync[SYNC_STAGES-2:0], bus.spiCk};
            di_sync  <= {di_sync[SYNC_STAGES-2:0], bus.spiDi};
            cs_q     <= cs_s;
            ck_q     <= ck_s;
            rx_valid <= 1'b0;

            // A load landing in the same clock as a consume refills the
            // holding register, so txFull stays set.
            if (consume) begin
                tx_full <= bus.txLoad;
                if (bus.txLoad) begin
                    hold <= bus.txData;
                end
            end else if (bus.txLoad && !tx_full) begin
                hold    <= bus.txData;
                tx_full <= 1'b1;
            end

            if (cs_s) begin
                // Deselected: drop any partial byte, keep the holding byte.
                bit_cnt <= 3'd0;
                spi_do  <= 1'b1;
            end else begin
                // spiDo tracks the shifter MSB, so a freshly loaded byte shows
                // its MSB before the first rising edge of that byte.
                spi_do <= tx_shift[7];

                if (reload) begin
                    tx_shift <= tx_full ? hold : FILL;
                end else if (ck_fall && (bit_cnt != 3'd0)) begin
                    tx_shift <= {tx_shift[6:0], 1'b1};
                end

                if (ck_rise) begin
                    rx_shift <= byte_done;
                    bit_cnt  <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        rx_data  <= byte_done;
                        rx_valid <= 1'b1;
                    end
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Command framer: advances on each received byte. Running one clock
    // behind rxValid keeps cmdValid and rxValid from coinciding.
    // -----------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset) begin
            frame_state <= HUNT;
            arg_n       <= 2'd0;
            idx_tmp     <= 6'd0;
            arg_sh      <= 32'd0;
            cmd_valid   <= 1'b0;
            cmd_error   <= 1'b0;
            cmd_index   <= 6'd0;
            cmd_arg     <= 32'd0;
            cmd_crc     <= 7'd0;
        end else begin
            cmd_valid <= 1'b0;
            cmd_error <= 1'b0;

            if (cs_s) begin
                frame_state <= HUNT;
            end else if (rx_valid) begin
                case (frame_state)
                    HUNT: begin
                        // Start bit 0 + transmission bit 1; anything else,
                        // such as 0xFF padding, is skipped.
                        if (rx_data[7:6] == 2'b01) begin
                            idx_tmp     <= rx_data[5:0];
                            arg_n       <= 2'd0;
                            frame_state <= ARG;
                        end
                    end
                    ARG: begin
                        arg_sh <= {arg_sh[23:0], rx_data};
                        arg_n  <= arg_n + 2'd1;
                        if (arg_n == 2'd3) begin
                            frame_state <= CRC;
                        end
                    end
                    CRC: begin
                        if (rx_data[0]) begin
                            cmd_index <= idx_tmp;
                            cmd_arg   <= arg_sh;
                            cmd_crc   <= rx_data[7:1];
                            cmd_valid <= 1'b1;
                        end else begin
                            cmd_error <= 1'b1;
                        end
                        frame_state <= HUNT;
                    end
                    default: frame_state <= HUNT;
                endcase
            end
        end
    end

    assign bus.spiDo      = spi_do;
    assign bus.rxData     = rx_data;
    assign bus.rxValid    = rx_valid;
    assign bus.txFull     = tx_full;
    assign bus.cmdValid   = cmd_valid;
    assign bus.cmdError   = cmd_error;
    assign bus.cmdIndex   = cmd_index;
    assign bus.cmdArg     = cmd_arg;
    assign bus.cmdCrc     = cmd_crc;
    assign bus.frameState = frame_state;

endmodule

// File: tb/tb_mmc_responder.sv
// ---------------------------------------------------------------------------
// tb_mmc_responder
// Directed bench for mmc_responder: an SPI mode-0 master bit-bangs the pins
// slowly (6 system clocks per SPI phase) and a backend loads response bytes.
// ---------------------------------------------------------------------------
module tb_mmc_responder;

    localparam int PHASE = 6;

    logic clock;
    logic reset;
    int   vectors;
    int   miscompares;

    int   rx_pulses;
    int   cmd_pulses;
    int   err_pulses;
    int   overlap;

    mmc_responder_if bus();

    mmc_responder #(
        .SYNC_STAGES (2),
        .FILL        (8'hFF)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Clock
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    // Pulse counters sampled away from the active edge
    initial begin
        rx_pulses  = 0;
        cmd_pulses = 0;
        err_pulses = 0;
        overlap    = 0;
    end
    always @(negedge clock) begin
        if (bus.rxValid === 1'b1)  rx_pulses++;
        if (bus.cmdValid === 1'b1) cmd_pulses++;
        if (bus.cmdError === 1'b1) err_pulses++;
        if (bus.rxValid === 1'b1 && bus.cmdValid === 1'b1) overlap++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic tx_load(input logic [7:0] v);
        bus.txData = v;
        bus.txLoad = 1'b1;
        wait_clks(1);
        bus.txLoad = 1'b0;
    endtask

    task automatic cs_low();
        bus.spiCs = 1'b0;
        wait_clks(8);
    endtask

    task automatic cs_high();
        bus.spiCs = 1'b1;
        wait_clks(10);
    endtask

    // Shift n bits MSB first; miso is sampled just before each rising edge.
    // With bnd_load set, a txLoad is placed on the clock in which the DUT
    // acts on the last rising edge (2 synchroniser clocks + 1).
    task automatic spi_bits(input logic [7:0] tx, input int n, input bit bnd_load,
                            input logic [7:0] bnd_data, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < n; i++) begin
            bus.spiDi = tx[7-i];
            wait_clks(PHASE);
            rx = {rx[6:0], bus.spiDo};
            bus.spiCk = 1'b1;
            if (bnd_load && (i == n - 1)) begin
                wait_clks(2);
                bus.txData = bnd_data;
                bus.txLoad = 1'b1;
                wait_clks(1);
                bus.txLoad = 1'b0;
                wait_clks(PHASE - 3);
            end else begin
                wait_clks(PHASE);
            end
            bus.spiCk = 1'b0;
        end
    endtask

    task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
        spi_bits(tx, 8, 1'b0, 8'h00, rx);
    endtask

    initial begin
        logic [7:0] miso;
        logic [7:0] t3 [7];
        logic [7:0] t4 [6];
        logic [7:0] t4e [6];
        logic [7:0] t6 [6];
        int rx0, cmd0, err0;

        t3  = '{8'hFF, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h95};
        t4  = '{8'h51, 8'h12, 8'h34, 8'h56, 8'h78, 8'hFF};
        t4e = '{8'h51, 8'hAB, 8'hCD, 8'hEF, 8'h01, 8'hFE};
        t6  = '{8'h48, 8'h00, 8'h00, 8'h01, 8'hAA, 8'h87};

        vectors     = 0;
        miscompares = 0;
        reset       = 1'b0;
        bus.spiCs   = 1'b0;
        bus.spiCk   = 1'b0;
        bus.spiDi   = 1'b1;
        bus.txData  = 8'h00;
        bus.txLoad  = 1'b0;

        // T1: reset held while the SPI pins wiggle and the backend loads
        wait_clks(3);
        for (int i = 0; i < 6; i++) begin
            bus.spiCk = ~bus.spiCk;
            bus.spiDi = ~bus.spiDi;
            wait_clks(4);
        end
        tx_load(8'h5A);
        wait_clks(2);
        check("t1_spido",   {31'd0, bus.spiDo},    32'd1);
        check("t1_txfull",  {31'd0, bus.txFull},   32'd0);
        check("t1_rxdata",  {24'd0, bus.rxData},   32'd0);
        check("t1_cmdidx",  {26'd0, bus.cmdIndex}, 32'd0);
        check("t1_cmdarg",  bus.cmdArg,            32'd0);
        check("t1_cmdcrc",  {25'd0, bus.cmdCrc},   32'd0);
        check("t1_state",   {30'd0, bus.frameState}, 32'd0);
        check("t1_pulses",  rx_pulses + cmd_pulses + err_pulses, 32'd0);

        bus.spiCs = 1'b1;
        bus.spiCk = 1'b0;
        wait_clks(2);
        reset = 1'b1;
        wait_clks(6);

        // T2: single byte loopback
        tx_load(8'hA5);
        check("t2_full_load", {31'd0, bus.txFull}, 32'd1);
        rx0 = rx_pulses;
        cs_low();
        check("t2_full_csfall", {31'd0, bus.txFull}, 32'd0);
        xfer(8'h3C, miso);
        check("t2_miso",    {24'd0, miso},        32'h0000_00A5);
        check("t2_rxdata",  {24'd0, bus.rxData},  32'h0000_003C);
        check("t2_rxpulse", rx_pulses - rx0,      32'd1);
        cs_high();
        check("t2_spido_idle", {31'd0, bus.spiDo}, 32'd1);

        // T3: CMD0 behind 0xFF padding; nothing queued, miso stays all-ones
        cmd0 = cmd_pulses;
        rx0  = rx_pulses;
        cs_low();
        for (int i = 0; i < 7; i++) begin
            xfer(t3[i], miso);
            if (i < 3) check("t3_underrun", {24'd0, miso}, 32'h0000_00FF);
        end
        check("t3_rxcount", rx_pulses - rx0,       32'd7);
        check("t3_cmdvalid", cmd_pulses - cmd0,    32'd1);
        check("t3_index",   {26'd0, bus.cmdIndex}, 32'd0);
        check("t3_arg",     bus.cmdArg,            32'd0);
        check("t3_crc",     {25'd0, bus.cmdCrc},   32'h0000_004A);
        cs_high();

        // T4: CMD17, then a frame with end bit 0 that must be dropped
        cmd0 = cmd_pulses;
        err0 = err_pulses;
        cs_low();
        for (int i = 0; i < 6; i++) xfer(t4[i], miso);
        check("t4_cmdvalid", cmd_pulses - cmd0,    32'd1);
        check("t4_index",   {26'd0, bus.cmdIndex}, 32'd17);
        check("t4_arg",     bus.cmdArg,            32'h1234_5678);
        check("t4_crc",     {25'd0, bus.cmdCrc},   32'h0000_007F);
        for (int i = 0; i < 6; i++) xfer(t4e[i], miso);
        check("t4e_cmderr",  err_pulses - err0,    32'd1);
        check("t4e_novalid", cmd_pulses - cmd0,    32'd1);
        check("t4e_index",  {26'd0, bus.cmdIndex}, 32'd17);
        check("t4e_arg",    bus.cmdArg,            32'h1234_5678);
        check("t4e_crc",    {25'd0, bus.cmdCrc},   32'h0000_007F);
        cs_high();

        // T5: overrun (22 dropped) and a load landing on the boundary clock
        cs_low();
        tx_load(8'h11);
        tx_load(8'h22);
        check("t5_full_11", {31'd0, bus.txFull}, 32'd1);
        xfer(8'h00, miso);
        check("t5_b1", {24'd0, miso}, 32'h0000_00FF);
        check("t5_empty_b1", {31'd0, bus.txFull}, 32'd0);
        tx_load(8'h33);
        spi_bits(8'h00, 8, 1'b1, 8'h44, miso);
        check("t5_b2", {24'd0, miso}, 32'h0000_0011);
        check("t5_full_bnd", {31'd0, bus.txFull}, 32'd1);
        xfer(8'h00, miso);
        check("t5_b3", {24'd0, miso}, 32'h0000_0033);
        xfer(8'h00, miso);
        check("t5_b4", {24'd0, miso}, 32'h0000_0044);
        xfer(8'h00, miso);
        check("t5_b5", {24'd0, miso}, 32'h0000_00FF);
        check("t5_empty_end", {31'd0, bus.txFull}, 32'd0);
        cs_high();

        // T6: abort after 4 argument bits, then a full CMD8
        rx0  = rx_pulses;
        cmd0 = cmd_pulses;
        cs_low();
        xfer(8'h48, miso);
        spi_bits(8'hFF, 4, 1'b0, 8'h00, miso);
        cs_high();
        check("t6_abort_rx",    rx_pulses - rx0,          32'd1);
        check("t6_abort_state", {30'd0, bus.frameState},  32'd0);
        cs_low();
        for (int i = 0; i < 6; i++) xfer(t6[i], miso);
        check("t6_cmdvalid", cmd_pulses - cmd0,    32'd1);
        check("t6_index",   {26'd0, bus.cmdIndex}, 32'd8);
        check("t6_arg",     bus.cmdArg,            32'h0000_01AA);
        check("t6_crc",     {25'd0, bus.cmdCrc},   32'h0000_0043);
        cs_high();

        // Reset in the middle of a command
        cs_low();
        tx_load(8'h77);
        xfer(8'h51, miso);
        xfer(8'h12, miso);
        check("t7_state_arg", {30'd0, bus.frameState}, 32'd1);
        rx0  = rx_pulses;
        cmd0 = cmd_pulses;
        err0 = err_pulses;
        reset = 1'b0;
        wait_clks(4);
        check("t7_state", {30'd0, bus.frameState}, 32'd0);
        check("t7_index", {26'd0, bus.cmdIndex},   32'd0);
        check("t7_arg",   bus.cmdArg,              32'd0);
        check("t7_rxdata", {24'd0, bus.rxData},    32'd0);
        check("t7_txfull", {31'd0, bus.txFull},    32'd0);
        check("t7_spido",  {31'd0, bus.spiDo},     32'd1);
        check("t7_nopulse", (rx_pulses - rx0) + (cmd_pulses - cmd0) + (err_pulses - err0), 32'd0);
        bus.spiCs = 1'b1;
        wait_clks(2);
        reset = 1'b1;
        wait_clks(4);

        check("overlap", overlap, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
